// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter/sequencer sharing one uart_tx among NUM_REQ clients
// Optional SEND watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                   clk_50M,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   timeout_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [7:0]         data_q, data_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               entry_q, entry_d;

    logic               found;
    logic [PW-1:0]      winner;
    logic [PW:0]        idx;
    logic               tx_ok;
    logic               timeout_hit;

    // First requester at or above the pointer, wrapping; the pointer slot has top priority.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

    // tx_done is ignored on the first SEND edge so a stale completion cannot end the new byte.
    assign tx_ok = (state_q == SEND) && !entry_q && tx_done;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        gnt_d   = '0;
        done_d  = '0;
        entry_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    data_d  = req_data[{winner, 3'b000} +: 8];
                    gnt_d   = NUM_REQ'(1) << winner;
                    owner_d = winner;
                    entry_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ok || timeout_hit) begin
                    done_d  = NUM_REQ'(1) << owner_q;
                    ptr_d   = (owner_q == PW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= 8'h00;
            gnt_q   <= '0;
            done_q  <= '0;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            entry_q <= entry_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;

    assign timeout_hit = (state_q == SEND) && (cnt_q == CW'(TIMEOUT_CYCLES-1));

    always_comb begin
        cnt_d  = cnt_q;
        terr_d = terr_q;
        if (entry_d) begin
            cnt_d = '0;
        end else if (state_q == SEND) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (timeout_hit && !tx_ok) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
    assign tx_en   = (state_q == SEND);
    assign tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a uart_tx response model
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 3;
    localparam int TMO   = 16;

    logic           clk_50M = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic           tx_en;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .timeout_err (timeout_err)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        int         id;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        logic [N-1:0] req;
        logic [31:0]  data;
        bit           hold;
        int           n;
        logic [15:0]  ord;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[6];
    int         tests = 0;
    int         fails = 0;
    int         mode, fcnt, win, exp_win, n_gnt, n_done, cur_id, hold_n;
    logic [7:0] cur_byte;
    logic       prev_en;
    bit         hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id = id;
        e.b  = req_data[8*id +: 8];
        sb.push_back(e);
    endtask

    // One clock: sample at negedge, score, then update requesters and the uart_tx model.
    task automatic tick();
        exp_t e;
        @(negedge clk_50M);
        if (gnt != '0) begin
            chk("gnt_gap", 32'(prev_en), 32'd0);
            chk("gnt_tx_en", 32'(tx_en), 32'd1);
            if (sb.size() == 0) begin
                chk("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                e        = sb.pop_front();
                cur_id   = e.id;
                cur_byte = e.b;
                chk("gnt_onehot", 32'(gnt), 32'(N'(1) << e.id));
                chk("gnt_byte", 32'(tx_data), 32'(e.b));
            end
            n_gnt++;
            win = 0;
            if (hold) begin
                if (n_gnt >= hold_n) req = '0;
            end else begin
                req = req & ~gnt;
            end
        end
        if (tx_en) begin
            win++;
            chk("tx_data_stable", 32'(tx_data), 32'(cur_byte));
        end
        if (done != '0) begin
            chk("done_onehot", 32'(done), 32'(N'(1) << cur_id));
            chk("done_tx_en", 32'(tx_en), 32'd0);
            chk("win_len", 32'(win), 32'(exp_win));
            n_done++;
        end
        prev_en = tx_en;
        case (mode)
            0: begin
                if (tx_en) begin
                    fcnt++;
                    tx_done = (fcnt >= FRAME);
                end else begin
                    fcnt    = 0;
                    tx_done = 1'b0;
                end
            end
            1: tx_done = 1'b0;
            default: tx_done = tx_en;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int n, input int budget);
        for (int c = 0; c < budget && n_done < n; c++) tick();
        chk("complete", 32'(n_done), 32'(n));
    endtask

    task automatic clear_state();
        sb.delete();
        req      = '0;
        mode     = 0;
        tx_done  = 1'b0;
        fcnt     = 0;
        hold     = 0;
        hold_n   = 0;
        exp_win  = FRAME;
        n_gnt    = 0;
        n_done   = 0;
        prev_en  = 1'b0;
        cur_id   = 0;
        cur_byte = 8'h00;
        win      = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_state();
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req_data = '0;
        clear_state();

        vecs[0] = '{req: 4'b0100, data: 32'h00F0_0000, hold: 0, n: 1, ord: 16'h0002};
        vecs[1] = '{req: 4'b1010, data: 32'hB300_A100, hold: 0, n: 2, ord: 16'h000D};
        vecs[2] = '{req: 4'b1111, data: 32'h4433_2211, hold: 1, n: 8, ord: 16'hE4E4};
        vecs[3] = '{req: 4'b0001, data: 32'h0000_005A, hold: 0, n: 1, ord: 16'h0000};
        vecs[4] = '{req: 4'b1100, data: 32'hC3E7_0000, hold: 0, n: 2, ord: 16'h000E};
        vecs[5] = '{req: 4'b0110, data: 32'h007E_8100, hold: 0, n: 2, ord: 16'h0009};

        foreach (vecs[v]) begin
            apply_reset();
            req_data = vecs[v].data;
            hold     = vecs[v].hold;
            hold_n   = vecs[v].n;
            for (int k = 0; k < vecs[v].n; k++) push(int'(vecs[v].ord[2*k +: 2]));
            req = vecs[v].req;
            tick();
            chk("gnt_latency", 32'(gnt != '0), 32'd1);
            run_until(vecs[v].n, 60 * vecs[v].n);
            idle(4);
            chk("vec_end_busy", 32'(busy), 32'd0);
            chk("vec_sb_empty", 32'(sb.size()), 32'd0);
            chk("vec_gnt_count", 32'(n_gnt), 32'(vecs[v].n));
            chk("vec_timeout_err", 32'(timeout_err), 32'd0);
            hold = 0;
        end

        // Short request pulse while busy is never served.
        apply_reset();
        req_data = 32'h003C_0055;
        push(2);
        req = 4'b0100;
        tick();
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        run_until(1, 60);
        idle(4);
        chk("pulse_gnt_count", 32'(n_gnt), 32'd1);
        chk("pulse_busy", 32'(busy), 32'd0);
        chk("pulse_sb_empty", 32'(sb.size()), 32'd0);

        // tx_done already high as tx_en rises: that edge is ignored, byte lasts two cycles.
        apply_reset();
        req_data = 32'h0000_00C9;
        mode     = 2;
        exp_win  = 2;
        push(0);
        req = 4'b0001;
        run_until(1, 20);
        idle(3);
        chk("early_busy", 32'(busy), 32'd0);

        // Reset mid-SEND after the pointer has moved, then first-match from pointer 0.
        apply_reset();
        req_data = 32'h9988_7766;
        push(1);
        req = 4'b0010;
        run_until(1, 60);
        idle(2);
        push(2);
        req = 4'b0100;
        tick();
        chk("ms_tx_en_up", 32'(tx_en), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("ms_tx_en_async", 32'(tx_en), 32'd0);
        chk("ms_busy_async", 32'(busy), 32'd0);
        chk("ms_gnt_async", 32'(gnt), 32'd0);
        chk("ms_done_async", 32'(done), 32'd0);
        clear_state();
        tick();
        tick();
        chk("ms_no_done", 32'(n_done), 32'd0);
        rst_n = 1'b1;
        push(1);
        push(3);
        req = 4'b1010;
        run_until(2, 120);
        idle(3);
        chk("ms_sb_empty", 32'(sb.size()), 32'd0);
        push(3);
        req = 4'b1000;
        run_until(3, 60);
        idle(3);
        chk("ms_last_busy", 32'(busy), 32'd0);

        // Stuck tx_done.
        apply_reset();
        req_data = 32'h6D00_4B00;
        mode     = 1;
`ifdef UART_ARB_TIMEOUT_EN
        exp_win = TMO;
        push(1);
        req = 4'b0010;
        run_until(1, 100);
        chk("tmo_err_set", 32'(timeout_err), 32'd1);
        idle(3);
        chk("tmo_busy", 32'(busy), 32'd0);
        mode    = 0;
        exp_win = FRAME;
        push(3);
        req = 4'b1000;
        run_until(2, 60);
        chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
`else
        push(1);
        req = 4'b0010;
        idle(40);
        chk("stuck_tx_en", 32'(tx_en), 32'd1);
        chk("stuck_timeout_err", 32'(timeout_err), 32'd0);
        chk("stuck_no_done", 32'(n_done), 32'd0);
        exp_win = win + FRAME;
        fcnt    = 0;
        mode    = 0;
        run_until(1, 60);
        idle(3);
        chk("stuck_busy", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
